tick_pwm: RTL and testbench

TICK_PWM -- requirements
Module: tick_pwm

---
 rtl/tick_pwm_pkg.sv | 11 +
 rtl/tick_pwm_edge_tick.sv | 23 ++
 rtl/tick_pwm.sv | 104 ++++++++++
 tb/tb_tick_pwm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_pwm_pkg.sv
// rtl/tick_pwm_pkg.sv - shared state encoding and default width for tick_pwm
package tick_pwm_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/tick_pwm_edge_tick.sv
// rtl/tick_pwm_edge_tick.sv - registered rising-edge detector with enable
module edge_tick (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   input  logic en,
   output logic pulse
);

   logic sig_d;

   // delay the input one cycle and emit a one-cycle pulse on each 0->1 while enabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sig_d <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sig_d <= sig;
         pulse <= sig & ~sig_d & en;
      end
   end

endmodule

// File: rtl/tick_pwm.sv
// rtl/tick_pwm.sv - tick-driven PWM generator with shadowed period/duty
module tick_pwm
   import tick_pwm_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_in,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] period,
   input  logic [WIDTH-1:0] duty,
   output logic             tick,
   output logic             pwm_out,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap,
   output logic             busy
);

   state_t           state;
   logic [WIDTH-1:0] per_sh;
   logic [WIDTH-1:0] duty_sh;
   logic             pend;
   logic [WIDTH-1:0] per_act;
   logic [WIDTH-1:0] duty_act;

   // values that an apply point would copy; a load in the same cycle bypasses the shadow
   logic [WIDTH-1:0] nxt_per;
   logic [WIDTH-1:0] nxt_duty;
   logic             nxt_pend;
   logic [WIDTH-1:0] idle_per;
   logic             last;

   assign nxt_per  = load ? period : per_sh;
   assign nxt_duty = load ? duty   : duty_sh;
   assign nxt_pend = load | pend;
   assign idle_per = nxt_pend ? nxt_per : per_act;

   // per_act is never 0 when this is used, so the subtraction cannot underflow
   assign last = (cnt >= (per_act - WIDTH'(1)));

   edge_tick u_edge_tick (
      .clk   (clk),
      .reset (reset),
      .sig   (div_in),
      .en    (en),
      .pulse (tick)
   );

   // control FSM: shadow capture, apply at idle or wrap, tick counting within the period
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         wrap     <= 1'b0;
         per_sh   <= '0;
         duty_sh  <= '0;
         pend     <= 1'b0;
         per_act  <= '0;
         duty_act <= '0;
      end else begin
         wrap <= 1'b0;
         if (load) begin
            per_sh  <= period;
            duty_sh <= duty;
            pend    <= 1'b1;
         end
         if (state == IDLE) begin
            cnt <= '0;
            if (nxt_pend) begin
               per_act  <= nxt_per;
               duty_act <= nxt_duty;
               pend     <= 1'b0;
            end
            if (en && (idle_per != '0)) begin
               state <= RUN;
            end
         end else begin
            if (!en || (per_act == '0)) begin
               state <= IDLE;
               cnt   <= '0;
            end else if (tick) begin
               if (last) begin
                  cnt  <= '0;
                  wrap <= 1'b1;
                  if (nxt_pend) begin
                     per_act  <= nxt_per;
                     duty_act <= nxt_duty;
                     pend     <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + WIDTH'(1);
               end
            end
         end
      end
   end

   // outputs decoded purely from registered state
   assign busy    = (state == RUN);
   assign pwm_out = busy & (cnt < duty_act);

endmodule

// File: tb/tb_tick_pwm.sv
// tb/tb_tick_pwm.sv - self-checking bench for tick_pwm
module tb_tick_pwm;

   logic       clk;
   logic       reset;
   logic       div_in;
   logic       en;
   logic       load;
   logic [7:0] period;
   logic [7:0] duty;
   logic       tick;
   logic       pwm_out;
   logic [7:0] cnt;
   logic       wrap;
   logic       busy;

   int checks = 0;
   int errors = 0;
   bit div_auto = 1'b1;
   int ph = 0;

   typedef struct {
      int per;
      int dut;
      bit run;
      int win;
      int ticks;
      int wraps;
      int pwm;
      int busyc;
      int maxc;
   } row_t;

   row_t rows[9];

   tick_pwm #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .div_in  (div_in),
      .en      (en),
      .load    (load),
      .period  (period),
      .duty    (duty),
      .tick    (tick),
      .pwm_out (pwm_out),
      .cnt     (cnt),
      .wrap    (wrap),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // upstream divide-by-3 stand-in: high one cycle out of three
   always @(negedge clk) begin
      if (div_auto) begin
         ph = (ph == 2) ? 0 : ph + 1;
         div_in = (ph == 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic advance(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic window(input int n, output int nt, output int nw, output int np,
                         output int nb, output int mx);
      nt = 0; nw = 0; np = 0; nb = 0; mx = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         nt += int'(tick);
         nw += int'(wrap);
         np += int'(pwm_out);
         nb += int'(busy);
         if (int'(cnt) > mx) mx = int'(cnt);
      end
   endtask

   task automatic wait_wrap(input string name);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!wrap && k < 100);
      check(name, int'(wrap), 1);
   endtask

   task automatic start_run(input int p, input int d);
      en = 1'b0;
      advance(2);
      period = 8'(p);
      duty = 8'(d);
      load = 1'b1;
      advance(1);
      load = 1'b0;
      en = 1'b1;
      advance(3);
   endtask

   initial begin
      int nt, nw, np, nb, mx;

      rows[0] = '{4, 1, 1'b1, 12, 4, 1, 3, 12, 3};
      rows[1] = '{4, 0, 1'b1, 12, 4, 1, 0, 12, 3};
      rows[2] = '{4, 5, 1'b1, 12, 4, 1, 12, 12, 3};
      rows[3] = '{2, 2, 1'b1, 12, 4, 2, 12, 12, 1};
      rows[4] = '{1, 1, 1'b1, 12, 4, 4, 12, 12, 0};
      rows[5] = '{3, 1, 1'b1, 36, 12, 4, 12, 36, 2};
      rows[6] = '{8, 3, 1'b1, 24, 8, 1, 9, 24, 7};
      rows[7] = '{4, 1, 1'b0, 12, 0, 0, 0, 0, 0};
      rows[8] = '{0, 2, 1'b1, 12, 4, 0, 0, 0, 0};

      reset = 1'b0;
      en = 1'b0;
      load = 1'b0;
      period = '0;
      duty = '0;
      div_in = 1'b0;

      // reset state, then en with no load stays idle while ticks keep coming
      advance(2);
      check("rst_busy", int'(busy), 0);
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_cnt", int'(cnt), 0);
      check("rst_wrap", int'(wrap), 0);
      check("rst_tick", int'(tick), 0);
      reset = 1'b1;
      en = 1'b1;
      advance(3);
      window(12, nt, nw, np, nb, mx);
      check("noload_ticks", nt, 4);
      check("noload_busy", nb, 0);
      check("noload_pwm", np, 0);

      // steady-state waveform per configuration
      for (int r = 0; r < 9; r++) begin
         en = 1'b0;
         advance(2);
         period = 8'(rows[r].per);
         duty = 8'(rows[r].dut);
         load = 1'b1;
         advance(1);
         load = 1'b0;
         advance(2);
         en = rows[r].run;
         advance(40);
         window(rows[r].win, nt, nw, np, nb, mx);
         check($sformatf("row%0d_ticks", r), nt, rows[r].ticks);
         check($sformatf("row%0d_wraps", r), nw, rows[r].wraps);
         check($sformatf("row%0d_pwm", r), np, rows[r].pwm);
         check($sformatf("row%0d_busy", r), nb, rows[r].busyc);
         check($sformatf("row%0d_maxcnt", r), mx, rows[r].maxc);
      end

      // count sequence 0,1,2,3,0 and 12-cycle wrap spacing
      start_run(4, 1);
      wait_wrap("seq_wrap0");
      check("seq_cnt_k0", int'(cnt), 0);
      advance(3);
      check("seq_cnt_k3", int'(cnt), 1);
      advance(3);
      check("seq_cnt_k6", int'(cnt), 2);
      advance(3);
      check("seq_cnt_k9", int'(cnt), 3);
      advance(2);
      check("seq_wrap_k11", int'(wrap), 0);
      advance(1);
      check("seq_cnt_k12", int'(cnt), 0);
      check("seq_wrap_k12", int'(wrap), 1);

      // reload at cnt=1: old waveform finishes, new one starts at the wrap
      start_run(4, 1);
      wait_wrap("rl_wrap0");
      advance(3);
      check("rl_cnt_at_load", int'(cnt), 1);
      period = 8'd2;
      duty = 8'd2;
      load = 1'b1;
      window(8, nt, nw, np, nb, mx);
      load = 1'b0;
      check("rl_old_pwm", np, 0);
      check("rl_old_nowrap", nw, 0);
      advance(1);
      check("rl_wrap_k12", int'(wrap), 1);
      window(12, nt, nw, np, nb, mx);
      check("rl_new_pwm", np, 12);
      check("rl_new_wraps", nw, 2);

      // en drop at cnt=2, then restart from 0
      start_run(4, 1);
      wait_wrap("en_wrap0");
      advance(6);
      check("en_cnt_pre", int'(cnt), 2);
      en = 1'b0;
      advance(1);
      check("en_off_busy", int'(busy), 0);
      check("en_off_cnt", int'(cnt), 0);
      check("en_off_pwm", int'(pwm_out), 0);
      en = 1'b1;
      advance(1);
      check("en_on_busy", int'(busy), 1);
      check("en_on_cnt", int'(cnt), 0);

      // asynchronous reset mid-period
      start_run(8, 3);
      wait_wrap("ar_wrap0");
      advance(9);
      check("ar_cnt_pre", int'(cnt), 3);
      #2 reset = 1'b0;
      #1;
      check("ar_busy", int'(busy), 0);
      check("ar_cnt", int'(cnt), 0);
      check("ar_pwm", int'(pwm_out), 0);
      check("ar_wrap", int'(wrap), 0);
      check("ar_tick", int'(tick), 0);
      @(negedge clk);
      reset = 1'b1;
      window(30, nt, nw, np, nb, mx);
      check("ar_post_busy", nb, 0);
      period = 8'd8;
      duty = 8'd3;
      load = 1'b1;
      advance(1);
      load = 1'b0;
      advance(2);
      check("ar_reload_busy", int'(busy), 1);

      // div_in held high across reset release gives exactly one tick
      div_auto = 1'b0;
      div_in = 1'b1;
      reset = 1'b0;
      advance(2);
      reset = 1'b1;
      window(6, nt, nw, np, nb, mx);
      check("held_ticks", nt, 1);
      div_auto = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
